// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit : instruction fetch stage.
//
// Fetches 32-bit instruction words from instruction memory over a req/ack
// handshake, buffers them in a DEPTH-entry prefetch queue and presents the
// queue head to the decoder with pre-split cond/op/funct/rd fields. A redirect
// (taken branch or PC write) flushes the queue and restarts fetch at the new
// address; a request already in flight at that moment completes on the bus
// and its data is thrown away.
//
// Optional feature (compile-time macro FETCH_BYPASS_EN):
//   defined   - with an empty queue, acked data is forwarded combinationally
//               to the head outputs in the ack cycle; if consumed in that
//               cycle it is never written to the queue.
//   undefined - acked data always passes through the queue (one cycle).
//
// Parameters:
//   DEPTH     prefetch queue entries (power of 2, >= 2)
//   RESET_PC  first fetch address after reset
//
// Ports:
//   clk_i, reset_i          clock, synchronous active-high reset
//   imem_req_o/imem_addr_o  request and word address, held until acked
//   imem_ack_i/imem_rdata_i single-cycle response strobe and data
//   redirect_valid_i/_pc_i  one-cycle redirect pulse and target
//   instr_valid_o/_ready_i  head handshake towards the decoder
//   instr_o, instr_pc_o     head word and its address
//   pc_plus8_o              instr_pc_o + 8 (R15 read value)
//   cond_o/op_o/funct_o/rd_o pre-split fields of instr_o
// ---------------------------------------------------------------------------
module fetch_unit #(
   parameter int          DEPTH    = 2,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk_i,
   input  logic        reset_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_ack_i,
   input  logic [31:0] imem_rdata_i,
   input  logic        redirect_valid_i,
   input  logic [31:0] redirect_pc_i,
   output logic        instr_valid_o,
   input  logic        instr_ready_i,
   output logic [31:0] instr_o,
   output logic [31:0] instr_pc_o,
   output logic [31:0] pc_plus8_o,
   output logic [3:0]  cond_o,
   output logic [1:0]  op_o,
   output logic [5:0]  funct_o,
   output logic [3:0]  rd_o
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_WAIT    = 2'd1,
      S_DISCARD = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [31:0]        fetch_pc_q, fetch_pc_d;
   logic               req_q, req_d;
   logic [31:0]        addr_q, addr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [31:0]        word_q [DEPTH];
   logic [31:0]        pc_q   [DEPTH];

   logic               ack_s;
   logic               empty_s;
   logic               byp_s;
   logic               pop_s;
   logic               push_s;
   logic               space_s;
   logic [CNT_W-1:0]   count_after_s;
   logic               head_valid_s;
   logic [31:0]        head_instr_s;
   logic [31:0]        head_pc_s;

   // An ack only counts while a request is actually outstanding.
   assign ack_s   = imem_ack_i & req_q;
   assign empty_s = (count_q == {CNT_W{1'b0}});
   assign pop_s   = ~empty_s & instr_ready_i;

`ifdef FETCH_BYPASS_EN
   assign byp_s        = empty_s & ack_s & (state_q == S_WAIT) & ~redirect_valid_i;
   assign head_valid_s = ~empty_s | byp_s;
   assign head_instr_s = byp_s ? imem_rdata_i : word_q[rd_ptr_q];
   assign head_pc_s    = byp_s ? addr_q : pc_q[rd_ptr_q];
`else
   assign byp_s        = 1'b0;
   assign head_valid_s = ~empty_s;
   assign head_instr_s = word_q[rd_ptr_q];
   assign head_pc_s    = pc_q[rd_ptr_q];
`endif

   // A bypassed word that is consumed in its ack cycle never occupies a slot.
   assign push_s        = ack_s & (state_q == S_WAIT) & ~redirect_valid_i & ~(byp_s & instr_ready_i);
   assign count_after_s = count_q + CNT_W'(push_s) - CNT_W'(pop_s);
   // Issuing only while a slot is still free after this cycle keeps
   // count + in-flight <= DEPTH, so a later push can never overflow.
   assign space_s       = (count_after_s < DEPTH_C);

   assign instr_valid_o = head_valid_s;
   assign instr_o       = head_instr_s;
   assign instr_pc_o    = head_pc_s;
   assign pc_plus8_o    = head_pc_s + 32'd8;
   assign cond_o        = head_instr_s[31:28];
   assign op_o          = head_instr_s[27:26];
   assign funct_o       = head_instr_s[25:20];
   assign rd_o          = head_instr_s[15:12];
   assign imem_req_o    = req_q;
   assign imem_addr_o   = addr_q;

   // Next-state logic for the fetch FSM, bus request and queue bookkeeping.
   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      req_d      = req_q;
      addr_d     = addr_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;
      if (redirect_valid_i) begin
         fetch_pc_d = {redirect_pc_i[31:2], 2'b00};
         rd_ptr_d   = {PTR_W{1'b0}};
         wr_ptr_d   = {PTR_W{1'b0}};
         count_d    = {CNT_W{1'b0}};
         case (state_q)
            S_IDLE: begin
               state_d = S_WAIT;
               req_d   = 1'b1;
               addr_d  = {redirect_pc_i[31:2], 2'b00};
            end
            S_WAIT, S_DISCARD: begin
               if (ack_s) begin
                  state_d = S_WAIT;
                  req_d   = 1'b1;
                  addr_d  = {redirect_pc_i[31:2], 2'b00};
               end else begin
                  // Old request stays on the bus until its ack arrives.
                  state_d = S_DISCARD;
               end
            end
            default: begin
               state_d = S_IDLE;
               req_d   = 1'b0;
            end
         endcase
      end else begin
         rd_ptr_d = pop_s  ? rd_ptr_q + PTR_W'(1'b1) : rd_ptr_q;
         wr_ptr_d = push_s ? wr_ptr_q + PTR_W'(1'b1) : wr_ptr_q;
         count_d  = count_after_s;
         case (state_q)
            S_IDLE: begin
               if (space_s) begin
                  state_d = S_WAIT;
                  req_d   = 1'b1;
                  addr_d  = fetch_pc_q;
               end else begin
                  state_d = S_IDLE;
               end
            end
            S_WAIT: begin
               if (ack_s) begin
                  fetch_pc_d = addr_q + 32'd4;
                  if (space_s) begin
                     state_d = S_WAIT;
                     req_d   = 1'b1;
                     addr_d  = addr_q + 32'd4;
                  end else begin
                     state_d = S_IDLE;
                     req_d   = 1'b0;
                  end
               end else begin
                  state_d = S_WAIT;
               end
            end
            S_DISCARD: begin
               if (ack_s) begin
                  state_d = S_WAIT;
                  req_d   = 1'b1;
                  addr_d  = fetch_pc_q;
               end else begin
                  state_d = S_DISCARD;
               end
            end
            default: begin
               state_d = S_IDLE;
               req_d   = 1'b0;
            end
         endcase
      end
   end

   // State, request and queue registers; queue storage written on push.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q    <= S_IDLE;
         fetch_pc_q <= RESET_PC;
         req_q      <= 1'b0;
         addr_q     <= RESET_PC;
         rd_ptr_q   <= {PTR_W{1'b0}};
         wr_ptr_q   <= {PTR_W{1'b0}};
         count_q    <= {CNT_W{1'b0}};
         for (int i = 0; i < DEPTH; i++) begin
            word_q[i] <= 32'h0000_0000;
            pc_q[i]   <= 32'h0000_0000;
         end
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         req_q      <= req_d;
         addr_q     <= addr_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         if (push_s) begin
            word_q[wr_ptr_q] <= imem_rdata_i;
            pc_q[wr_ptr_q]   <= addr_q;
         end else begin
            word_q[wr_ptr_q] <= word_q[wr_ptr_q];
         end
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit : self-checking bench for fetch_unit.
// A memory responder acks requests after a programmable delay and returns a
// word derived from the address. A transaction-level model tracks the
// expected consumed-instruction stream, queue occupancy, stale in-flight
// fetches and the next expected bus request.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

   localparam int          DEPTH    = 2;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef FETCH_BYPASS_EN
   localparam logic BYP = 1'b1;
`else
   localparam logic BYP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = 32'h0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        instr_valid;
   logic        instr_ready = 1'b0;
   logic [31:0] instr, instr_pc, pc_plus8;
   logic [3:0]  cond, rd;
   logic [1:0]  op;
   logic [5:0]  funct;

   always #5 clk = ~clk;

   fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk_i(clk), .reset_i(reset),
      .imem_req_o(imem_req), .imem_addr_o(imem_addr),
      .imem_ack_i(imem_ack), .imem_rdata_i(imem_rdata),
      .redirect_valid_i(redirect_valid), .redirect_pc_i(redirect_pc),
      .instr_valid_o(instr_valid), .instr_ready_i(instr_ready),
      .instr_o(instr), .instr_pc_o(instr_pc), .pc_plus8_o(pc_plus8),
      .cond_o(cond), .op_o(op), .funct_o(funct), .rd_o(rd)
   );

   int total = 0;
   int bad   = 0;

   // memory responder knobs
   int   dmin = 0, dmax = 0, wait_left = 0;
   logic force_ack = 1'b0;

   // reference model
   int          m_occ = 0;
   logic        m_stale = 1'b0;
   logic [31:0] m_fetch = RESET_PC;
   logic [31:0] m_head = RESET_PC;
   logic        m_chk = 1'b0;
   logic        m_exp_req = 1'b0;
   logic [31:0] m_exp_addr = RESET_PC;

   // observation log
   logic [31:0] cons_q[$];
   int          ack_cnt = 0;
   logic        did_pop = 1'b0;
   logic        ack_cycle_valid = 1'b0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0000_0300) return 32'hE591_2004;
      return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
   endfunction

   function automatic int dly();
      return dmin + int'($urandom % (dmax - dmin + 1));
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock cycle: respond on the bus, check outputs, advance the model.
   task automatic cycle();
      logic        req_now, ack_s, good, exp_valid, popv;
      logic [31:0] ew, tgt;
      req_now = imem_req;
      if (req_now) imem_ack = (wait_left == 0);
      else         imem_ack = force_ack;
      imem_rdata = imem_ack ? mem_word(imem_addr) : $urandom;
      #1;
      did_pop = 1'b0;
      if (!reset) begin
         if (m_chk) begin
            chk("imem_req", {31'd0, imem_req}, {31'd0, m_exp_req});
            if (m_exp_req) chk("imem_addr", imem_addr, m_exp_addr);
         end
         ack_s = imem_ack && req_now;
         good  = ack_s && !m_stale && !redirect_valid;
         exp_valid = (m_occ > 0) || (BYP && good && m_occ == 0);
         if (ack_s) begin
            ack_cnt++;
            ack_cycle_valid = instr_valid;
         end
         chk("instr_valid", {31'd0, instr_valid}, {31'd0, exp_valid});
         popv = exp_valid && instr_ready && !redirect_valid;
         if (popv) begin
            ew = mem_word(m_head);
            chk("instr_pc", instr_pc, m_head);
            chk("instr", instr, ew);
            chk("pc_plus8", pc_plus8, m_head + 32'd8);
            chk("cond", {28'd0, cond}, {28'd0, ew[31:28]});
            chk("op", {30'd0, op}, {30'd0, ew[27:26]});
            chk("funct", {26'd0, funct}, {26'd0, ew[25:20]});
            chk("rd", {28'd0, rd}, {28'd0, ew[15:12]});
            cons_q.push_back(instr_pc);
            did_pop = 1'b1;
         end
         if (redirect_valid) begin
            tgt = {redirect_pc[31:2], 2'b00};
            m_occ = 0; m_fetch = tgt; m_head = tgt;
            m_exp_req = 1'b1;
            if (req_now && !ack_s) m_stale = 1'b1;
            else begin m_stale = 1'b0; m_exp_addr = tgt; end
         end else begin
            if (good) begin m_occ++; m_fetch = m_exp_addr + 32'd4; end
            if (popv) begin m_occ--; m_head = m_head + 32'd4; end
            if (req_now && !ack_s) m_exp_req = 1'b1;
            else if (ack_s && m_stale) begin
               m_stale = 1'b0; m_exp_req = 1'b1; m_exp_addr = m_fetch;
            end else if (m_occ < DEPTH) begin
               m_exp_req = 1'b1; m_exp_addr = m_fetch;
            end else m_exp_req = 1'b0;
         end
         m_chk = 1'b1;
      end
      @(posedge clk);
      #1;
      if (reset) begin
         m_occ = 0; m_stale = 1'b0; m_fetch = RESET_PC; m_head = RESET_PC;
         m_exp_req = 1'b0; m_exp_addr = RESET_PC; m_chk = 1'b1;
         wait_left = dly();
      end else if (imem_ack && req_now) wait_left = dly();
      else if (req_now && wait_left > 0) wait_left--;
      redirect_valid = 1'b0;
      force_ack = 1'b0;
      imem_ack = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      cycle();
      cycle();
      reset = 1'b0;
   endtask

   initial begin
      int n, stall, max_stall;
      logic found;

      // --- reset state
      dmin = 0; dmax = 0;
      do_reset();
      chk("rst_req", {31'd0, imem_req}, 32'd0);
      chk("rst_addr", imem_addr, RESET_PC);
      chk("rst_valid", {31'd0, instr_valid}, 32'd0);
      chk("rst_instr", instr, 32'd0);
      chk("rst_pc", instr_pc, 32'd0);
      chk("rst_fields", {18'd0, cond, op, funct, rd}, 32'd0);

      // --- streaming with ready held, zero-wait memory
      instr_ready = 1'b1;
      cons_q.delete();
      for (int i = 0; i < 12; i++) cycle();
      chk("seq_len_ok", {31'd0, cons_q.size() >= 3}, 32'd1);
      if (cons_q.size() >= 3) begin
         chk("seq0", cons_q[0], 32'h0);
         chk("seq1", cons_q[1], 32'h4);
         chk("seq2", cons_q[2], 32'h8);
      end

      // --- ready held low: exactly DEPTH fetches then stop
      instr_ready = 1'b0;
      do_reset();
      ack_cnt = 0;
      for (int i = 0; i < 10; i++) cycle();
      chk("full_acks", ack_cnt, 32'd2);
      chk("full_req", {31'd0, imem_req}, 32'd0);
      chk("full_head", instr_pc, 32'h0);
      chk("full_p8", pc_plus8, 32'h8);
      instr_ready = 1'b1;
      cycle();
      chk("resume_req", {31'd0, imem_req}, 32'd1);
      chk("resume_addr", imem_addr, 32'h8);

      // --- redirect while fetch of 8 is pending
      dmin = 3; dmax = 3;
      do_reset();
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         if (imem_req && imem_addr == 32'h8) found = 1'b1;
         else cycle();
      end
      chk("pend8_found", {31'd0, found}, 32'd1);
      redirect_pc = 32'h100; redirect_valid = 1'b1;
      cycle();
      chk("rdr_valid", {31'd0, instr_valid}, 32'd0);
      n = 0;
      while (!instr_valid && n < 40) begin cycle(); n++; end
      chk("rdr_head", instr_pc, 32'h100);

      // --- redirect in the ack cycle
      dmin = 2; dmax = 2;
      instr_ready = 1'b0;
      do_reset();
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         if (imem_req && wait_left == 0) found = 1'b1;
         else cycle();
      end
      chk("ackcyc_found", {31'd0, found}, 32'd1);
      redirect_pc = 32'h203; redirect_valid = 1'b1;
      cycle();
      chk("ackrdr_valid", {31'd0, instr_valid}, 32'd0);
      chk("ackrdr_req", {31'd0, imem_req}, 32'd1);
      chk("ackrdr_addr", imem_addr, 32'h200);

      // --- field decode
      redirect_pc = 32'h300; redirect_valid = 1'b1;
      cycle();
      n = 0;
      while (!instr_valid && n < 40) begin cycle(); n++; end
      chk("fld_pc", instr_pc, 32'h300);
      chk("fld_cond", {28'd0, cond}, 32'hE);
      chk("fld_op", {30'd0, op}, 32'h1);
      chk("fld_funct", {26'd0, funct}, 32'h19);
      chk("fld_rd", {28'd0, rd}, 32'h2);

      // --- reset in WAIT, then a late ack while idle
      dmin = 5; dmax = 5;
      instr_ready = 1'b1;
      do_reset();
      n = 0;
      while (!imem_req && n < 20) begin cycle(); n++; end
      cycle();
      cycle();
      chk("mid_inwait", {31'd0, imem_req}, 32'd1);
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      chk("mid_req", {31'd0, imem_req}, 32'd0);
      chk("mid_valid", {31'd0, instr_valid}, 32'd0);
      force_ack = 1'b1;
      cycle();
      chk("late_req", {31'd0, imem_req}, 32'd1);
      chk("late_addr", imem_addr, RESET_PC);
      chk("late_valid", {31'd0, instr_valid}, 32'd0);

      // --- ack-to-visibility latency with an empty queue
      dmin = 1; dmax = 1;
      instr_ready = 1'b0;
      do_reset();
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         if (imem_req && wait_left == 0) found = 1'b1;
         else cycle();
      end
      chk("lat_found", {31'd0, found}, 32'd1);
      cycle();
      chk("lat_ackcyc", {31'd0, ack_cycle_valid}, {31'd0, BYP});
      chk("lat_next", {31'd0, instr_valid}, 32'd1);

      // --- randomized traffic against the model
      dmin = 0; dmax = 3;
      do_reset();
      cons_q.delete();
      stall = 0; max_stall = 0;
      for (int i = 0; i < 1500; i++) begin
         instr_ready = ($urandom % 4) != 0;
         if (($urandom % 25) == 0) begin
            redirect_valid = 1'b1;
            if (($urandom % 6) == 0) redirect_pc = 32'hFFFF_FFF0 | ($urandom % 16);
            else                     redirect_pc = $urandom & 32'h0000_0FFF;
         end
         cycle();
         if (did_pop) stall = 0;
         else stall++;
         if (stall > max_stall) max_stall = stall;
      end
      chk("rnd_stall", {31'd0, max_stall > 60}, 32'd0);
      chk("rnd_progress", {31'd0, cons_q.size() > 200}, 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
